// File: rtl/onewire_responder_if.sv
// rtl/onewire_responder_if.sv - 1-wire responder pad and byte handshake bundle
interface onewire_responder_if;
    logic       owr_i;
    logic       owr_oe;
    logic       rst_det;
    logic [7:0] rx_dat;
    logic       rx_vld;
    logic [7:0] tx_dat;
    logic       tx_vld;
    logic       tx_rdy;

    modport slave (
        input  owr_i, tx_dat, tx_vld,
        output owr_oe, rst_det, rx_dat, rx_vld, tx_rdy
    );

    modport master (
        output owr_i, tx_dat, tx_vld,
        input  owr_oe, rst_det, rx_dat, rx_vld, tx_rdy
    );
endinterface

// File: rtl/onewire_responder.sv
// rtl/onewire_responder.sv - 1-wire byte-level responder with reset/presence handling
module onewire_responder #(
    parameter  int CDR = 10,
    localparam int CW  = $clog2(960*CDR+1)
) (
    input logic                clk,
    input logic                rst_n,
    onewire_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SLOT, WREL, RSTL, PWAIT, PRES, PREL} state_t;

    localparam logic [CW-1:0] T_DRV_END   = CW'(30*CDR - 1);
    localparam logic [CW-1:0] T_SAMPLE    = CW'(30*CDR);
    // Low time seen in WREL is cnt+2: the IDLE detection cycle plus cnt+1 counted cycles.
    localparam logic [CW-1:0] T_RST       = CW'(480*CDR - 2);
    localparam logic [CW-1:0] T_PWAIT_END = CW'(30*CDR - 1);
    localparam logic [CW-1:0] T_PRES_END  = CW'(120*CDR - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    state_t        state;
    logic          s_meta;
    logic          s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_shift;
    logic [7:0]    tx_buf;
    logic          tx_full;
    logic          rdy_en;
    logic          owr_oe_q;
    logic          rst_det_q;
    logic          rx_vld_q;
    logic [7:0]    rx_dat_q;

    logic          tx_rdy_w;
    logic          tx_load;
    logic [7:0]    tx_byte;
    logic          tx_drive0;

    // A byte accepted in the same cycle as a falling edge must already drive that first slot.
    assign tx_rdy_w  = rdy_en && (state == IDLE) && !tx_full && (bit_cnt == 3'd0);
    assign tx_load   = bus.tx_vld && tx_rdy_w;
    assign tx_byte   = tx_full ? tx_buf : bus.tx_dat;
    assign tx_drive0 = (tx_full || tx_load) && !tx_byte[bit_cnt];

    assign bus.owr_oe  = owr_oe_q;
    assign bus.rst_det = rst_det_q;
    assign bus.rx_dat  = rx_dat_q;
    assign bus.rx_vld  = rx_vld_q;
    assign bus.tx_rdy  = tx_rdy_w;

    // Two-flop synchronizer for the asynchronous line; idles high like the pulled-up bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
        end else begin
            s_meta <= bus.owr_i;
            s      <= s_meta;
        end
    end

    // Slot, reset and presence sequencing with registered line drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            tx_buf    <= 8'h00;
            tx_full   <= 1'b0;
            rdy_en    <= 1'b0;
            owr_oe_q  <= 1'b0;
            rst_det_q <= 1'b0;
            rx_vld_q  <= 1'b0;
            rx_dat_q  <= 8'h00;
        end else begin
            rdy_en    <= 1'b1;
            rst_det_q <= 1'b0;
            rx_vld_q  <= 1'b0;
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            if (tx_load) begin
                tx_buf  <= bus.tx_dat;
                tx_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!s) begin
                        state    <= SLOT;
                        cnt      <= '0;
                        owr_oe_q <= tx_drive0;
                    end
                end
                SLOT: begin
                    if (cnt == T_DRV_END) owr_oe_q <= 1'b0;
                    if (cnt == T_SAMPLE) begin
                        rx_shift[bit_cnt] <= s;
                        state             <= WREL;
                    end
                end
                WREL: begin
                    if (s) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_dat_q <= rx_shift;
                            rx_vld_q <= 1'b1;
                            tx_full  <= 1'b0;
                        end
                    end else if (cnt >= T_RST) begin
                        state <= RSTL;
                        cnt   <= '0;
                    end
                end
                RSTL: begin
                    if (s) begin
                        rst_det_q <= 1'b1;
                        bit_cnt   <= 3'd0;
                        rx_shift  <= 8'h00;
                        tx_full   <= 1'b0;
                        state     <= PWAIT;
                        cnt       <= '0;
                    end
                end
                PWAIT: begin
                    if (cnt == T_PWAIT_END) begin
                        state    <= PRES;
                        cnt      <= '0;
                        owr_oe_q <= 1'b1;
                    end
                end
                PRES: begin
                    if (cnt == T_PRES_END) begin
                        state    <= PREL;
                        cnt      <= '0;
                        owr_oe_q <= 1'b0;
                    end
                end
                PREL: begin
                    if (s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    owr_oe_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onewire_responder.sv
// tb/tb_onewire_responder.sv - scoreboard bench for onewire_responder
module tb_onewire_responder;
    localparam int CDR     = 10;
    localparam int SLOT_T  = 65 * CDR;
    localparam int LOW1_T  = 6 * CDR;
    localparam int LOW0_T  = 60 * CDR;
    localparam int RSTLO_T = 480 * CDR;
    localparam int RSTRC_T = 170 * CDR;
    localparam int LAT     = 3;

    typedef struct {
        int dly;
        int wid;
    } pulse_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_low = 1'b0;
    int   cyc = 0;
    int   edge_cyc = 0;

    int n_checks = 0;
    int n_err = 0;

    logic [7:0] rx_q[$];
    int         rst_q[$];
    pulse_t     pulse_q[$];

    int         pos = 0;
    logic [7:0] acc = 8'h00;
    bit         tx_pend = 1'b0;
    logic [7:0] tx_b = 8'h00;

    onewire_responder_if bus();

    assign bus.owr_i = !(m_low || bus.owr_oe);

    onewire_responder #(.CDR(CDR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void fail(input string nm, input int act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %0d with nothing expected", nm, act);
    endfunction

    // Reference model: each slot yields the wire-AND of the master bit and the responder bit.
    function automatic void model_slot(input bit mb);
        bit w;
        pulse_t p;
        w = mb;
        if (tx_pend && !tx_b[pos]) begin
            w = 1'b0;
            p.dly = LAT;
            p.wid = 30 * CDR;
            pulse_q.push_back(p);
        end
        acc[pos] = w;
        pos++;
        if (pos == 8) begin
            rx_q.push_back(acc);
            pos = 0;
            tx_pend = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        pulse_t p;
        rst_q.push_back(1);
        p.dly = 30 * CDR + LAT;
        p.wid = 120 * CDR;
        pulse_q.push_back(p);
        pos = 0;
        tx_pend = 1'b0;
    endfunction

    task automatic mslot(input bit mb, input int low_t, input int tot_t);
        model_slot(mb);
        @(posedge clk); #1;
        m_low = 1'b1;
        edge_cyc = cyc;
        repeat (low_t) @(posedge clk);
        #1;
        m_low = 1'b0;
        edge_cyc = cyc;
        repeat (tot_t - low_t) @(posedge clk);
    endtask

    task automatic wbit(input bit b);
        mslot(b, b ? LOW1_T : LOW0_T, SLOT_T);
    endtask

    task automatic wbyte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) wbit(d[i]);
    endtask

    task automatic rbyte();
        for (int i = 0; i < 8; i++) mslot(1'b1, LOW1_T, SLOT_T);
    endtask

    task automatic mreset_low();
        model_reset();
        @(posedge clk); #1;
        m_low = 1'b1;
        edge_cyc = cyc;
        repeat (RSTLO_T) @(posedge clk);
        #1;
        m_low = 1'b0;
        edge_cyc = cyc;
    endtask

    task automatic tx_offer(input logic [7:0] d, input bit exp_rdy);
        @(posedge clk); #1;
        chk("tx_rdy_offer", bus.tx_rdy, exp_rdy);
        bus.tx_dat = d;
        bus.tx_vld = 1'b1;
        if (exp_rdy) begin
            tx_pend = 1'b1;
            tx_b = d;
        end
        @(posedge clk); #1;
        bus.tx_vld = 1'b0;
    endtask

    task automatic chk_rdy(input string nm, input bit exp);
        @(posedge clk); #1;
        chk(nm, bus.tx_rdy, exp);
    endtask

    // Monitor: pops expectations whenever the responder produces an event.
    bit     in_pulse = 1'b0;
    int     wcnt = 0;
    pulse_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pulse = 1'b0;
        end else begin
            if (bus.owr_oe && !in_pulse) begin
                in_pulse = 1'b1;
                wcnt = 1;
                if (pulse_q.size() == 0) begin
                    fail("owr_oe_unexpected", cyc - edge_cyc);
                    cur.dly = -1;
                    cur.wid = -1;
                end else begin
                    cur = pulse_q.pop_front();
                    chk("owr_oe_delay", cyc - edge_cyc, cur.dly);
                end
            end else if (bus.owr_oe) begin
                wcnt++;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                chk("owr_oe_width", wcnt, cur.wid);
            end
            if (bus.rx_vld) begin
                if (rx_q.size() == 0) fail("rx_vld_unexpected", bus.rx_dat);
                else chk("rx_dat", bus.rx_dat, rx_q.pop_front());
            end
            if (bus.rst_det) begin
                if (rst_q.size() == 0) fail("rst_det_unexpected", 1);
                else chk("rst_det", 1, rst_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] d;
        bit b;
        int k;
        bus.tx_vld = 1'b0;
        bus.tx_dat = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset_owr_oe", bus.owr_oe, 0);
        chk("reset_rst_det", bus.rst_det, 0);
        chk("reset_rx_dat", bus.rx_dat, 0);
        chk("reset_rx_vld", bus.rx_vld, 0);
        chk("reset_tx_rdy", bus.tx_rdy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk_rdy("tx_rdy_after_reset", 1'b1);

        mreset_low();
        repeat (RSTRC_T) @(posedge clk);

        wbyte(8'h55);
        repeat (2) wbyte(8'($urandom_range(0, 255)));

        tx_offer(8'hA3, 1'b1);
        tx_offer(8'h3C, 1'b0);
        rbyte();
        chk_rdy("tx_rdy_after_read", 1'b1);

        d = 8'($urandom_range(0, 255));
        tx_offer(d, 1'b1);
        rbyte();

        mslot(1'b0, 400 * CDR, 410 * CDR);
        chk_rdy("tx_rdy_after_400us", 1'b0);
        for (int i = 0; i < 7; i++) begin
            b = 1'($urandom_range(0, 1));
            wbit(b);
        end
        chk_rdy("tx_rdy_after_400us_byte", 1'b1);

        tx_offer(8'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 3; i++) begin
            b = 1'($urandom_range(0, 1));
            wbit(b);
        end
        chk_rdy("tx_rdy_mid_byte", 1'b0);
        mreset_low();
        repeat (RSTRC_T) @(posedge clk);
        chk_rdy("tx_rdy_after_bus_reset", 1'b1);
        wbyte(8'($urandom_range(0, 255)));

        mreset_low();
        k = 0;
        while (k < 2000 && !bus.owr_oe) begin
            @(negedge clk);
            k++;
        end
        chk("presence_seen", bus.owr_oe, 1);
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("owr_oe_async_release", bus.owr_oe, 0);
        pos = 0;
        tx_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk_rdy("tx_rdy_after_rst_n", 1'b1);
        wbyte(8'($urandom_range(0, 255)));

        repeat (20) @(posedge clk);
        chk("rx_q_drained", rx_q.size(), 0);
        chk("rst_q_drained", rst_q.size(), 0);
        chk("pulse_q_drained", pulse_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
